// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep controller: word width, sweep modes, FSM states.
package dds_pkg;

  localparam int unsigned FW_W = 8;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_TRI  = 2'b10;
  localparam logic [1:0] MODE_SAW  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } sweep_state_t;

endpackage

// File: rtl/dds_dwell_cnt.sv
// Loadable dwell down-counter; expire is registered and high during the last cycle of a dwell.
module dds_dwell_cnt #(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt_q;

  // cnt_q holds the cycles remaining in the current dwell, including the present one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      expire <= 1'b0;
    end else if (load) begin
      cnt_q  <= load_val;
      expire <= (load_val == DWELL_W'(1));
    end else if (cnt_q > DWELL_W'(1)) begin
      cnt_q  <= cnt_q - DWELL_W'(1);
      expire <= (cnt_q == DWELL_W'(2));
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the DDS frequency word from f_start toward f_stop with a dwell per step.
module dds_sweep_ctrl #(
  parameter int unsigned FW_W    = dds_pkg::FW_W,
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [FW_W-1:0]    f_start,
  input  logic [FW_W-1:0]    f_stop,
  input  logic [FW_W-1:0]    f_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [FW_W-1:0]    p_word_in,
  output logic [FW_W-1:0]    F_word,
  output logic [FW_W-1:0]    P_word,
  output logic               sin_en,
  output logic               busy,
  output logic               done
);

  import dds_pkg::*;

  sweep_state_t       state_q, state_d;
  logic [1:0]         mode_q;
  logic [FW_W-1:0]    fs_q, fe_q, s_q;
  logic [DWELL_W-1:0] d_q;
  logic               dir_q, dir_d;

  logic [FW_W-1:0]    f_d, p_d;
  logic               sin_en_d, busy_d, done_d;
  logic               start_acc, cnt_load, expire;
  logic [DWELL_W-1:0] cnt_val;

  logic [DWELL_W-1:0] dwell_eff;
  logic [FW_W-1:0]    step_eff;

  assign dwell_eff = (dwell == '0)  ? DWELL_W'(1) : dwell;
  assign step_eff  = (f_step == '0) ? FW_W'(1)    : f_step;

  // Add with carry; clamp to lim on overflow or on reaching/passing lim
  function automatic logic [FW_W-1:0] step_up(input logic [FW_W-1:0] a,
                                              input logic [FW_W-1:0] s,
                                              input logic [FW_W-1:0] lim);
    logic [FW_W:0] sum;
    sum = {1'b0, a} + {1'b0, s};
    if (sum[FW_W] || (sum[FW_W-1:0] >= lim)) return lim;
    return sum[FW_W-1:0];
  endfunction

  // Subtract with borrow; clamp to lim on borrow or on reaching/passing lim
  function automatic logic [FW_W-1:0] step_dn(input logic [FW_W-1:0] a,
                                              input logic [FW_W-1:0] s,
                                              input logic [FW_W-1:0] lim);
    logic [FW_W:0] diff;
    diff = {1'b0, a} - {1'b0, s};
    if (diff[FW_W] || (diff[FW_W-1:0] <= lim)) return lim;
    return diff[FW_W-1:0];
  endfunction

  dds_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .expire   (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= 1'b1;
      F_word  <= '0;
      P_word  <= '0;
      sin_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      F_word  <= f_d;
      P_word  <= p_d;
      sin_en  <= sin_en_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Sweep configuration is frozen for the whole run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_UP;
      fs_q   <= '0;
      fe_q   <= '0;
      s_q    <= '0;
      d_q    <= '0;
    end else if (start_acc) begin
      mode_q <= mode;
      fs_q   <= f_start;
      fe_q   <= f_stop;
      s_q    <= step_eff;
      d_q    <= dwell_eff;
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    f_d       = F_word;
    p_d       = P_word;
    sin_en_d  = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    start_acc = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = d_q;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          start_acc = 1'b1;
          state_d   = RUN;
          dir_d     = 1'b1;
          f_d       = f_start;
          p_d       = p_word_in;
          sin_en_d  = 1'b1;
          busy_d    = 1'b1;
          cnt_load  = 1'b1;
          cnt_val   = dwell_eff;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          sin_en_d = 1'b1;
          busy_d   = 1'b1;
          if (expire) begin
            cnt_load = 1'b1;
            case (mode_q)
              MODE_UP: begin
                if (F_word >= fe_q) state_d = DONE;
                else f_d = step_up(F_word, s_q, fe_q);
              end
              MODE_DOWN: begin
                if (F_word <= fe_q) state_d = DONE;
                else f_d = step_dn(F_word, s_q, fe_q);
              end
              MODE_TRI: begin
                // Degenerate range holds f_start; otherwise turn around at each end
                if (fs_q >= fe_q) begin
                  f_d = fs_q;
                end else if (dir_q) begin
                  if (F_word >= fe_q) begin
                    dir_d = 1'b0;
                    f_d   = step_dn(F_word, s_q, fs_q);
                  end else begin
                    f_d = step_up(F_word, s_q, fe_q);
                  end
                end else begin
                  if (F_word <= fs_q) begin
                    dir_d = 1'b1;
                    f_d   = step_up(F_word, s_q, fe_q);
                  end else begin
                    f_d = step_dn(F_word, s_q, fs_q);
                  end
                end
              end
              default: begin
                if (F_word >= fe_q) f_d = fs_q;
                else f_d = step_up(F_word, s_q, fe_q);
              end
            endcase
            if (state_d == DONE) begin
              cnt_load = 1'b0;
              sin_en_d = 1'b0;
              busy_d   = 1'b0;
              done_d   = 1'b1;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer for the DDS sine generator. It latches a sweep configuration on a start pulse and steps the generator's frequency control word from a start value to a stop value. Each frequency is held for a programmable dwell time, and the sweep runs single-shot up, single-shot down, continuous triangle or continuous sawtooth. It sits between the front-panel/register logic and the DDS generator, driving the generator's `F_word`, `P_word` and `sin_en` inputs.

## Interface
Parameters:
- `FW_W`, 8, width of the frequency/phase words.
- `DWELL_W`, 16, width of the dwell count.

Ports:
- `clk`, in, 1, system clock.
- `rst_n`, in, 1, asynchronous active-low reset.
- `start`, in, 1, one-cycle pulse; accepted only in IDLE.
- `stop`, in, 1, one-cycle pulse; aborts the sweep.
- `mode`, in, 2, sweep mode: 00 up-once, 01 down-once, 10 triangle (continuous), 11 sawtooth-up (continuous).
- `f_start`, in, FW_W, first frequency word.
- `f_stop`, in, FW_W, end frequency word.
- `f_step`, in, FW_W, increment; 0 is treated as 1.
- `dwell`, in, DWELL_W, clocks per frequency; 0 is treated as 1.
- `p_word_in`, in, FW_W, phase word forwarded for the whole sweep.
- `F_word`, out, FW_W, frequency word to the generator.
- `P_word`, out, FW_W, phase word to the generator.
- `sin_en`, out, 1, generator enable.
- `busy`, out, 1, sweep in progress.
- `done`, out, 1, one-cycle completion pulse (single-shot modes only).

## Operation
- States and transitions:
  - IDLE: waits for `start`, then goes to RUN.
  - RUN: holds the current frequency for D cycles, then steps or goes to DONE.
  - DONE: lasts one cycle, then returns to IDLE.
- On an accepted `start`, all inputs are latched. Input changes during a sweep have no effect. `start` is ignored in RUN and DONE.
- D = max(`dwell`,1) and S = max(`f_step`,1).
- Up step: next = cur+S, computed FW_W+1 wide. If next ≥ `f_stop` or the add overflows, next = `f_stop`.
- Down step: next = cur−S. If the subtract borrows or next ≤ `f_stop`, next = `f_stop`.
- Up-once: the first frequency is `f_start`. If `f_start` ≥ `f_stop`, only `f_start` is dwelt, then DONE. Otherwise steps up until `f_stop` has been dwelt, then DONE.
- Down-once: mirror of up-once, with `f_start` ≤ `f_stop` giving a single dwell.
- Triangle:
  - Up toward `f_stop`, then down toward `f_start`, repeating. The down step clamps at `f_start` rather than `f_stop`.
  - Turnaround points are dwelt once.
  - If `f_start` ≥ `f_stop`, `f_start` is held indefinitely.
- Sawtooth: up toward `f_stop`; after `f_stop` has been dwelt, reloads `f_start`.
- Continuous modes end only on `stop` and never pulse `done`.
- `stop` in RUN:
  - Next state is IDLE; `sin_en`=0 and `busy`=0 from the next edge.
  - `F_word`/`P_word` hold their last values; no `done` pulse.
- `start` and `stop` together in IDLE: `stop` wins, the block stays in IDLE.
- Reset, including mid-sweep: IDLE, and all outputs 0 (`F_word`, `P_word`, `sin_en`, `busy`, `done`).

## Timing
- `start` sampled at edge N. From N+1: `busy`=1, `sin_en`=1, `F_word`=`f_start`, `P_word`=`p_word_in` (latched).
- Each frequency is presented for exactly D consecutive cycles.
- `F_word` changes on the edge ending the D-th cycle; `sin_en` stays 1 with no gap between frequencies.
- After the last dwell, one DONE cycle: `done`=1, `busy`=0, `sin_en`=0, `F_word` holds the final value.
- The following cycle is IDLE; a `start` is accepted there at the earliest.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `dds_pkg`:
  - `FW_W`.
  - Mode encodings `MODE_UP`, `MODE_DOWN`, `MODE_TRI`, `MODE_SAW`.
  - State enum `sweep_state_t` (IDLE, RUN, DONE).
- One sub-module, `dds_dwell_cnt`: loadable down-counter (load D, assert `expire` on the last cycle), parameterised by DWELL_W.
- Step/clamp arithmetic and the direction flag live in the top module.

## Test plan
- Up-once, `f_start`=10, `f_stop`=40, `f_step`=10, `dwell`=3 → `F_word` 10,20,30,40 for 3 cycles each, `sin_en` high 12 cycles, `done` on cycle 13 after `start`, `busy` high cycles 1–12.
- Up-once clamp, 250→255, step 10, `dwell`=1 → `F_word` 250 then 255 (overflow clamped), then `done`. Down-once 40→10, step 15 → 40, 25, 10.
- Triangle, 5→15, step 5, `dwell`=1 → 5,10,15,10,5,10,15… After `stop`: next cycle `sin_en`=0, `busy`=0, `F_word` held, `done`=0.
- Zero handling: `dwell`=0, `f_step`=0, up 0→3 → 0,1,2,3 for one cycle each. `f_start`=`f_stop`=7 → a single dwell at 7, then `done`.
- Handshake: `start`+`stop` in the same IDLE cycle → stays IDLE. A second `start` with a different config during RUN → ignored, original sweep completes unchanged.
- Reset: assert `rst_n` low mid-sweep → all outputs 0 immediately (async). After release, the block accepts a new `start`.
